// File: rtl/timer_irq_source_pkg.sv
// Shared register map, TCON bit positions and default base address for the interval timer.
// Imported by the timer top and its prescaler.
package timer_irq_source_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    localparam logic [31:0] OFF_TH   = 32'd0;
    localparam logic [31:0] OFF_TL   = 32'd4;
    localparam logic [31:0] OFF_TCON = 32'd8;
    localparam logic [31:0] OFF_PSC  = 32'd12;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the count-enable by PSC+1: tick fires when DIV reaches PSC, then DIV restarts.
// Latency: tick is combinational from DIV/PSC/en. No backpressure; PSC write takes one edge.
module timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  pscWrite,
    input  logic [PRESCALE_W-1:0] pscWdata,
    output logic [PRESCALE_W-1:0] psc,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] div;

    assign tick = en && (div == psc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
            psc <= '0;
        end else begin
            if (pscWrite) begin
                psc <= pscWdata;
            end
            // A new divide ratio always restarts the period from zero.
            if (pscWrite || tick) begin
                div <= '0;
            end else if (en) begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer (TH reload, TL counter, TCON) raising a level IRQ on TL wrap.
// Latency: reads combinational, writes/counting on the clk edge. No backpressure. TIMER_PRESCALE_EN adds PSC.
module timer_irq_source
    import timer_irq_source_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        tick_out
);

    if (PRESCALE_W < 1 || PRESCALE_W > 32) begin : gBadPrescaleW
        $error("timer_irq_source: PRESCALE_W must be 1..32");
    end

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic        tickOut;

    logic selTh, selTl, selTcon;
    logic tick, wrap, setStatus;

    assign selTh   = (addr == BASE_ADDR + OFF_TH);
    assign selTl   = (addr == BASE_ADDR + OFF_TL);
    assign selTcon = (addr == BASE_ADDR + OFF_TCON);

`ifdef TIMER_PRESCALE_EN
    logic                  selPsc;
    logic [PRESCALE_W-1:0] psc;

    assign selPsc = (addr == BASE_ADDR + OFF_PSC);

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (tcon[TCON_EN]),
        .pscWrite (MemWrite && selPsc),
        .pscWdata (wdata[PRESCALE_W-1:0]),
        .psc      (psc),
        .tick     (tick)
    );
`else
    assign tick = tcon[TCON_EN];
`endif

    assign wrap      = tick && (tl == 32'hFFFF_FFFF);
    assign setStatus = wrap && tcon[TCON_IE];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            tickOut <= 1'b0;
        end else begin
            tickOut <= wrap;

            if (MemWrite && selTh) begin
                th <= wdata;
            end

            // Software writes to TL override the count in that cycle.
            if (MemWrite && selTl) begin
                tl <= wdata;
            end else if (wrap) begin
                tl <= th;
            end else if (tick) begin
                tl <= tl + 32'd1;
            end

            // A hardware set of the status bit beats a simultaneous software clear.
            if (MemWrite && selTcon) begin
                tcon[TCON_EN] <= wdata[TCON_EN];
                tcon[TCON_IE] <= wdata[TCON_IE];
                tcon[TCON_ST] <= wdata[TCON_ST] | setStatus;
            end else if (setStatus) begin
                tcon[TCON_ST] <= 1'b1;
            end
        end
    end

    assign irq      = tcon[TCON_IE] & tcon[TCON_ST];
    assign tick_out = tickOut;

    always_comb begin
        rdata = 32'h0;
        if (MemRead) begin
            if (selTh) begin
                rdata = th;
            end else if (selTl) begin
                rdata = tl;
            end else if (selTcon) begin
                rdata = {29'b0, tcon};
            end
`ifdef TIMER_PRESCALE_EN
            else if (selPsc) begin
                rdata = 32'(psc);
            end
`endif
        end
    end

endmodule

// File: doc/timer_irq_source.md
Name: timer_irq_source

Overview:
- Memory-mapped 32-bit interval timer on the peripheral bus.
- Generates the level-sensitive IRQ that the pipeline controller consumes to divert the pipeline into the exception handler.
- Software programs the reload value TH, the counter TL and the control word TCON through the MEM-stage bus, and clears the interrupt from the handler.

Parameters:
- BASE_ADDR, 32'h4000_0000, word address of TH; TL at +4, TCON at +8.
- PRESCALE_W, 8, width of the prescaler counter; only used when TIMER_PRESCALE_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from the MEM stage.
- MemRead  in  1  bus read strobe.
- MemWrite  in  1  bus write strobe.
- wdata  in  32  write data.
- rdata  out  32  read data.
- irq  out  1  interrupt request to the controller.
- tick_out  out  1  one-cycle pulse on each TL wrap, for debug and LEDs.

Behaviour:
- Registers:
  - TH[31:0] holds the reload value.
  - TL[31:0] is the counter.
  - TCON[2:0]: bit0 = timer enable, bit1 = interrupt enable, bit2 = interrupt status.
- Reset (reset low, asynchronous): TH=0, TL=0, TCON=0, tick_out=0. Because irq is derived from TCON, irq=0.
- Address decode:
  - Only addr[31:0] equal to BASE_ADDR, BASE_ADDR+4 or BASE_ADDR+8 selects a register.
  - Any other address is ignored and reads return 32'h0.
- Read path:
  - Combinational, zero latency.
  - rdata = selected register when MemRead=1, else 32'h0.
  - A TCON read returns {29'b0, TCON}.
- Write path: takes effect at the rising clk edge while MemWrite=1. A TCON write loads wdata[2:0].
- Count enable tick:
  - Without the optional feature, tick=TCON[0] on every cycle.
- Counting on each tick:
  - If TL != 32'hFFFF_FFFF, TL <= TL+1.
  - If TL == 32'hFFFF_FFFF, then TL <= TH, tick_out pulses high for one cycle, and TCON[2] <= 1 if TCON[1]=1.
- irq = TCON[1] & TCON[2], registered-output only. There is no combinational path from bus inputs to irq.
- Simultaneous events:
  - Write to TL and tick in the same cycle: the write wins and no increment occurs that cycle.
  - Write to TH and wrap in the same cycle: the reload uses the old TH; the new TH is visible from the next cycle.
  - Write to TCON and wrap in the same cycle: bits 0/1 take wdata. Bit2 = wdata[2] OR (wrap & TCON_old[1]), so a set beats a software clear and no interrupt is lost.
- Clearing the interrupt: the handler writes TCON with bit2=0, and irq deasserts on the following cycle.
- Disabling: writing TCON[0]=0 freezes TL at its current value and preserves the prescaler state.
- Reset mid-count: all state is cleared immediately and counting resumes only after software sets TCON[0].

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- When defined:
  - A PRESCALE_W-bit register PSC is mapped at BASE_ADDR+12 (read/write, reset 0), and a divider counter DIV (reset 0) is added.
  - tick = TCON[0] & (DIV == PSC).
  - DIV resets to 0 on a tick, else increments while TCON[0]=1.
  - PSC=0 gives behaviour identical to the non-prescaled timer.
  - Writing PSC also clears DIV.
- When undefined: BASE_ADDR+12 is unmapped (reads 0, writes ignored) and no PSC or DIV logic exists.

Decomposition:
- Shared package holds:
  - register offsets: OFF_TH=0, OFF_TL=4, OFF_TCON=8, OFF_PSC=12;
  - TCON bit indices: TCON_EN=0, TCON_IE=1, TCON_ST=2;
  - the default BASE_ADDR.
- One sub-module, timer_prescaler, contains DIV, PSC and the tick generation. It is instantiated only under TIMER_PRESCALE_EN; otherwise tick=TCON[0].

Test Plan:
- Reset/readback:
  - Assert reset low mid-run: irq=0 and TL, TH, TCON read 0.
  - Write TH=32'h1234_5678: the next-cycle read returns 32'h1234_5678.
  - A read at 0x4000_0010 returns 0.
- Wrap and IRQ:
  - Set TH=32'hFFFF_FFFD, TL=32'hFFFF_FFFD, TCON=3'b011.
  - After 2 cycles TL=FFFF_FFFF; on the 3rd edge TL=FFFF_FFFD, tick_out pulses and irq=1.
- Interrupt enable off:
  - Same setup with TCON=3'b001: TL wraps with tick_out=1, but TCON[2] stays 0 and irq stays 0.
- Clear race:
  - With irq=1, write TCON=3'b011 on the exact cycle of the next wrap: TCON reads 3'b111 and irq stays 1.
  - A write one cycle later clears irq.
- Write/tick collision:
  - Counting with TL=32'h10, write TL=32'h100 during counting: TL=32'h100 next cycle, then 32'h101.
  - With TCON[0]=0, TL holds its value for 10 cycles.
- Prescaler (TIMER_PRESCALE_EN):
  - Set PSC=3, TL=0, TCON=1: TL increments every 4 cycles, reaching TL=5 after 20 cycles.
  - With PSC=0, TL increments every cycle.
